// File: rtl/rgb_pwm_gen.sv
// Three-channel PWM generator with a double-buffered duty triple for the RGB LED driver.
// Latency: outputs registered one cycle after the counter state; a new triple takes effect at the next period boundary.
// Backpressure: duty_ready drops once a triple is pending and returns the cycle after the boundary that consumes it.
module rgb_pwm_gen #(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 16
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic             enable,
    input  logic [WIDTH-1:0] duty_r,
    input  logic [WIDTH-1:0] duty_g,
    input  logic [WIDTH-1:0] duty_b,
    input  logic             duty_valid,
    output logic             duty_ready,
    output logic             red_pwm,
    output logic             green_pwm,
    output logic             blue_pwm,
    output logic             period_start
);

    localparam int              PSC_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] CNT_LAST = {WIDTH{1'b1}};

    // Pending-slot states
    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [PSC_W-1:0]      psc_q, psc_d;
    logic [WIDTH-1:0]      cnt_q, cnt_d;
    logic [0:0]            state_q, state_d;
    logic [2:0][WIDTH-1:0] pend_q, pend_d;
    logic [2:0][WIDTH-1:0] act_q, act_d;
    logic [2:0]            pwm_q, pwm_d;
    logic                  period_start_q, period_start_d;

    logic                  tick;
    logic                  bnd;
    logic [2:0][WIDTH-1:0] duty_in;

    assign duty_in = {duty_b, duty_g, duty_r};

    // Prescaler tick and period boundary; with enable low every cycle is a
    // boundary so a waiting triple is promoted without running the counters.
    always_comb begin
        tick = (psc_q == PSC_LAST);
        bnd  = enable ? (tick && (cnt_q == CNT_LAST)) : 1'b1;
    end

    // Prescaler and PWM step counter, both held at zero while disabled
    always_comb begin
        psc_d = psc_q;
        cnt_d = cnt_q;
        if (!enable) begin
            psc_d = '0;
            cnt_d = '0;
        end else if (tick) begin
            psc_d = '0;
            cnt_d = cnt_q + WIDTH'(1);
        end else begin
            psc_d = psc_q + PSC_W'(1);
        end
    end

    // Pending slot: capture only while empty, promote to active only at a
    // boundary while full, so a capture coinciding with a boundary waits a period.
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        act_d   = act_q;
        if (state_q == ST_EMPTY) begin
            if (duty_valid) begin
                state_d = ST_FULL;
                pend_d  = duty_in;
            end
        end else begin
            if (bnd) begin
                state_d = ST_EMPTY;
                act_d   = pend_q;
            end
        end
    end

    // Per-channel compare against the shared counter keeps channels phase-aligned
    always_comb begin
        pwm_d = '0;
        for (int c = 0; c < 3; c++) begin
            pwm_d[c] = enable && (cnt_q < act_q[c]);
        end
        period_start_d = enable && (psc_q == '0) && (cnt_q == '0);
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            psc_q          <= '0;
            cnt_q          <= '0;
            state_q        <= ST_EMPTY;
            pend_q         <= '0;
            act_q          <= '0;
            pwm_q          <= '0;
            period_start_q <= 1'b0;
        end else begin
            psc_q          <= psc_d;
            cnt_q          <= cnt_d;
            state_q        <= state_d;
            pend_q         <= pend_d;
            act_q          <= act_d;
            pwm_q          <= pwm_d;
            period_start_q <= period_start_d;
        end
    end

    assign duty_ready   = (state_q == ST_EMPTY);
    assign red_pwm      = pwm_q[0];
    assign green_pwm    = pwm_q[1];
    assign blue_pwm     = pwm_q[2];
    assign period_start = period_start_q;

endmodule

// File: tb/tb_rgb_pwm_gen.sv
// Directed bench for rgb_pwm_gen at WIDTH=8, PRESCALE=2 (512-cycle period).
// Outputs sampled 1 time unit after each rising edge; inputs changed at the same point.
// Expected high times, ready windows and accept positions are hand-derived constants.
`timescale 1ns/1ps
module tb_rgb_pwm_gen;

    localparam int WIDTH    = 8;
    localparam int PRESCALE = 2;
    localparam int PERIOD   = 512;

    logic             HCLK = 1'b0;
    logic             HRESETn;
    logic             enable;
    logic [WIDTH-1:0] duty_r, duty_g, duty_b;
    logic             duty_valid;
    logic             duty_ready;
    logic             red_pwm, green_pwm, blue_pwm;
    logic             period_start;

    int n_checks = 0;
    int n_fail   = 0;

    rgb_pwm_gen #(.WIDTH(WIDTH), .PRESCALE(PRESCALE)) dut (
        .HCLK         (HCLK),
        .HRESETn      (HRESETn),
        .enable       (enable),
        .duty_r       (duty_r),
        .duty_g       (duty_g),
        .duty_b       (duty_b),
        .duty_valid   (duty_valid),
        .duty_ready   (duty_ready),
        .red_pwm      (red_pwm),
        .green_pwm    (green_pwm),
        .blue_pwm     (blue_pwm),
        .period_start (period_start)
    );

    always #5 HCLK = ~HCLK;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic set_duty(input int r, input int g, input int b);
        duty_r = WIDTH'(r);
        duty_g = WIDTH'(g);
        duty_b = WIDTH'(b);
    endtask

    // Walks one period starting at a period_start sample. If offer_at >= 0 the
    // preset duty bus is offered for exactly one cycle at that sample index.
    task automatic measure(input int offer_at, output int rh, output int gh, output int bh,
                           output int ps, output int rr, output int rdy_lo, output int first_hi);
        logic prev_r;
        rh = 0; gh = 0; bh = 0; ps = 0; rr = 0; rdy_lo = 0; first_hi = -1;
        prev_r = 1'b0;
        for (int i = 0; i < PERIOD; i++) begin
            rh += int'(red_pwm);
            gh += int'(green_pwm);
            bh += int'(blue_pwm);
            ps += int'(period_start);
            if (red_pwm === 1'b1 && prev_r === 1'b0) rr++;
            prev_r = red_pwm;
            if (offer_at >= 0 && i > offer_at) begin
                if (duty_ready !== 1'b1) rdy_lo++;
                else if (first_hi < 0) first_hi = i;
            end
            duty_valid = (i == offer_at);
            step();
        end
        duty_valid = 1'b0;
    endtask

    task automatic expect_period(input string tag, input int offer_at,
                                 input int rh_e, input int gh_e, input int bh_e,
                                 input int rdy_lo_e, input int first_hi_e);
        int rh, gh, bh, ps, rr, rdy_lo, first_hi;
        measure(offer_at, rh, gh, bh, ps, rr, rdy_lo, first_hi);
        check_val({tag, "_red_hi"},   rh, rh_e);
        check_val({tag, "_green_hi"}, gh, gh_e);
        check_val({tag, "_blue_hi"},  bh, bh_e);
        check_val({tag, "_ps_count"}, ps, 1);
        check_val({tag, "_red_rises"}, rr, (rh_e > 0) ? 1 : 0);
        check_val({tag, "_next_ps"},  period_start, 1);
        if (offer_at >= 0) begin
            check_val({tag, "_rdy_lo_cycles"}, rdy_lo, rdy_lo_e);
            check_val({tag, "_rdy_first_hi"},  first_hi, first_hi_e);
        end
    endtask

    initial begin
        int idx;

        HRESETn    = 1'b0;
        enable     = 1'b0;
        duty_valid = 1'b0;
        set_duty(0, 0, 0);

        // Reset held for three edges, then idle with enable low
        for (int i = 0; i < 3; i++) begin
            step();
            check_val("rst_red", red_pwm, 0);
            check_val("rst_ps", period_start, 0);
            check_val("rst_ready", duty_ready, 1);
        end
        HRESETn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check_val("idle_outs", {period_start, blue_pwm, green_pwm, red_pwm}, 0);
            check_val("idle_ready", duty_ready, 1);
        end

        // Accept while disabled: promoted on the next edge since every cycle is a boundary
        set_duty(64, 128, 0);
        duty_valid = 1'b1;
        step();
        check_val("acc_ready_lo", duty_ready, 0);
        duty_valid = 1'b0;
        step();
        check_val("xfer_ready_hi", duty_ready, 1);

        // First enabled edge: period_start and PWM high on the very next cycle
        enable = 1'b1;
        step();
        check_val("en_ps", period_start, 1);
        check_val("en_red", red_pwm, 1);
        check_val("en_green", green_pwm, 1);
        check_val("en_blue", blue_pwm, 0);
        expect_period("p0", -1, 128, 256, 0, 0, 0);

        // Mid-period update: current period unchanged, ready low 101..510
        set_duty(200, 32, 255);
        expect_period("p1_upd", 100, 128, 256, 0, 410, 511);

        // New values in force; offer coinciding with the boundary at sample 510
        set_duty(16, 0, 100);
        expect_period("p2_bnd", 510, 400, 64, 510, 1, -1);
        check_val("p3_ready_lo", duty_ready, 0);
        expect_period("p3_old", -1, 400, 64, 510, 0, 0);
        expect_period("p4_new", -1, 32, 0, 200, 0, 0);

        // Back-pressure: A accepted at once, B held until the slot frees
        set_duty(100, 0, 0);
        duty_valid = 1'b1;
        step();
        set_duty(50, 150, 250);
        idx = -1;
        for (int i = 1; i < 2000; i++) begin
            if (duty_ready === 1'b1) begin
                idx = i;
                step();
                break;
            end
            step();
        end
        duty_valid = 1'b0;
        check_val("bp_accept_idx", idx, 511);
        check_val("bp_ps", period_start, 1);
        check_val("bp_ready_lo", duty_ready, 0);
        expect_period("p6_a", -1, 200, 0, 0, 0, 0);
        set_duty(255, 255, 255);
        expect_period("p7_b", 0, 100, 300, 500, 510, 511);
        expect_period("p8_max", -1, 510, 510, 510, 0, 0);

        // Reset during a high pulse, with a triple offered in the reset cycle
        for (int i = 0; i < 10; i++) step();
        check_val("pre_rst_red", red_pwm, 1);
        HRESETn = 1'b0;
        set_duty(77, 77, 77);
        duty_valid = 1'b1;
        step();
        check_val("mid_rst_outs", {period_start, blue_pwm, green_pwm, red_pwm}, 0);
        check_val("mid_rst_ready", duty_ready, 1);
        HRESETn = 1'b1;
        duty_valid = 1'b0;
        step();
        check_val("post_rst_ps", period_start, 1);
        check_val("post_rst_red", red_pwm, 0);
        check_val("post_rst_ready", duty_ready, 1);
        expect_period("post_rst", -1, 0, 0, 0, 0, 0);

        // Disable mid-run, load while disabled, then re-enable
        for (int i = 0; i < 5; i++) step();
        enable = 1'b0;
        step();
        check_val("dis_outs", {period_start, blue_pwm, green_pwm, red_pwm}, 0);
        set_duty(20, 40, 60);
        duty_valid = 1'b1;
        step();
        check_val("dis_acc_ready", duty_ready, 0);
        duty_valid = 1'b0;
        step();
        check_val("dis_xfer_ready", duty_ready, 1);
        check_val("dis_outs_hold", {period_start, blue_pwm, green_pwm, red_pwm}, 0);
        enable = 1'b1;
        step();
        check_val("reen_ps", period_start, 1);
        check_val("reen_red", red_pwm, 1);
        expect_period("reen", -1, 40, 80, 120, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
